// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline's memory-port arbiter and control unit:
// arbiter state encoding, abort read data and MIPS opcodes.
package mips_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_RESP_D = 3'd3;
    localparam logic [2:0] ST_RESP_I = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_FETCH  = ST_FETCH,
        S_RESP_D = ST_RESP_D,
        S_RESP_I = ST_RESP_I
    } arb_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter that flags an outstanding memory access as hung once it has
// waited TIMEOUT cycles without an acknowledge.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The first busy cycle sees a count of 0, so the last allowed cycle is TIMEOUT-1.
    assign expired_c_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and load/store,
// stalling the pipeline while an access is outstanding and aborting hung accesses.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter int unsigned    TIMEOUT  = 16,
    parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          flushW,
    output logic          bus_err
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          bus_err_q, bus_err_d;
    logic          busy_c;
    logic          expired_c;

    assign busy_c = (state_q == S_DATA) || (state_q == S_FETCH);

    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (!busy_c),
        .en_i       (busy_c),
        .expired_c_o(expired_c)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        bus_err_d   = bus_err_q;
        unique case (state_q)
            S_IDLE: begin
                // Data access has priority; dm_rd together with dm_wr is a store.
                if (dm_rd || dm_wr) begin
                    state_d     = S_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_wr;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_req) begin
                    state_d    = S_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            S_DATA: begin
                if (mem_ack) begin
                    state_d    = S_RESP_D;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (expired_c) begin
                    state_d    = S_RESP_D;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = ERR_DATA;
                    bus_err_d  = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d    = S_RESP_I;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (expired_c) begin
                    state_d    = S_RESP_I;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = ERR_DATA;
                    bus_err_d  = 1'b1;
                end
            end
            S_RESP_D, S_RESP_I: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign bus_err   = bus_err_q;

    // Released exactly in the valid cycle so each stalled stage advances once.
    assign stall  = ((dm_rd || dm_wr) && !dm_valid_q) || (if_req && !if_valid_q);
    assign flushW = stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected
// completions, a negedge monitor checks every valid pulse against them.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          is_data;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          flushW;
    logic          bus_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .flushW(flushW), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic d, input logic [DW-1:0] r, input logic e);
        exp_t x;
        x.is_data = d;
        x.rdata   = r;
        x.err     = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_req_wait: mem_req never rose within 50 cycles", name);
        end
    endtask

    // Memory model: checks the request, then acks 'delay' cycles after mem_req rises.
    task automatic serve(input string name, input logic [AW-1:0] addr, input logic we,
                         input logic [DW-1:0] wdata, input int delay, input logic [DW-1:0] rdata);
        bit ok;
        wait_req(name, ok);
        if (!ok) return;
        check({name, "_addr"}, mem_addr, addr);
        check({name, "_we"}, 32'(mem_we), 32'(we));
        if (we) check({name, "_wdata"}, mem_wdata, wdata);
        @(posedge clk); #1;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            check({name, "_req_hold"}, 32'(mem_req), 32'd1);
            check({name, "_we_hold"}, 32'(mem_we), 32'(we));
            if (we) check({name, "_wdata_hold"}, mem_wdata, wdata);
            @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        check({name, "_stall_busy"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Monitor: every valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && (dm_valid || if_valid)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: dm_valid=%0b if_valid=%0b with nothing expected",
                         dm_valid, if_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid_kind", 32'({dm_valid, if_valid}), mon_e.is_data ? 32'd2 : 32'd1);
                check("valid_rdata", mon_e.is_data ? dm_rdata : if_rdata, mon_e.rdata);
                check("valid_bus_err", 32'(bus_err), 32'(mon_e.err));
                check("valid_flushW", 32'(flushW), 32'(stall));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ok;
        int cnt;
        int t0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_valids", 32'({if_valid, dm_valid}), 32'd0);
        check("rst_rdata", if_rdata | dm_rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch only, ack two cycles after mem_req
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        push_exp(1'b0, 32'h20080005, 1'b0);
        serve("fetch", 32'h40, 1'b0, '0, 2, 32'h20080005);
        @(negedge clk);
        check("fetch_stall_released", 32'(stall), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Simultaneous load and fetch: load first, fetch after, load not re-issued
        @(posedge clk); #1;
        t0 = cyc;
        dm_rd = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
        push_exp(1'b1, 32'hAAAA0001, 1'b0);
        push_exp(1'b0, 32'h20090007, 1'b0);
        serve("load", 32'h100, 1'b0, '0, 1, 32'hAAAA0001);
        check("load_latency", 32'(cyc - t0), 32'd3);
        @(negedge clk);
        check("resp_d_req_low", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        dm_rd = 1'b0;
        serve("fetch2", 32'h44, 1'b0, '0, 1, 32'h20090007);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Store: dm_rdata keeps the previous load value
        @(posedge clk); #1;
        dm_wr = 1'b1; dm_addr = 32'h104; dm_wdata = 32'h55;
        push_exp(1'b1, 32'hAAAA0001, 1'b0);
        serve("store", 32'h104, 1'b1, 32'h55, 3, 32'h12345678);
        @(posedge clk); #1;
        dm_wr = 1'b0;

        // Stray ack while idle
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("stray_mem_req", 32'(mem_req), 32'd0);
        check("stray_stall", 32'(stall), 32'd0);
        check("stray_dm_rdata", dm_rdata, 32'hAAAA0001);
        check("stray_if_rdata", if_rdata, 32'h20090007);

        // Hung load: abort after 16 cycles of mem_req, sticky bus error
        @(posedge clk); #1;
        dm_rd = 1'b1; dm_addr = 32'h200;
        push_exp(1'b1, 32'hDEADBEEF, 1'b1);
        wait_req("timeout", ok);
        if (ok) begin
            cnt = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!mem_req) break;
                cnt++;
            end
            check("timeout_req_cycles", 32'(cnt), 32'd16);
            check("timeout_bus_err", 32'(bus_err), 32'd1);
        end
        @(posedge clk); #1;
        dm_rd = 1'b0;
        repeat (5) @(negedge clk);
        check("bus_err_sticky", 32'(bus_err), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h48;
        push_exp(1'b0, 32'h11112222, 1'b1);
        serve("fetch_after_err", 32'h48, 1'b0, '0, 2, 32'h11112222);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Reset during a fetch, then a late ack
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h4C;
        wait_req("rst_fetch", ok);
        @(posedge clk); #1;
        rst_n = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_rdata", if_rdata | dm_rdata, 32'd0);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_if_rdata", if_rdata, 32'd0);
        check("late_ack_bus_err", 32'(bus_err), 32'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
